flash_read_cache: RTL and testbench
===================================

Name: flash_read_cache

Overview:
- Sits between the 6809 bus / flash address decoder and the SPI flash read controller.
- Serves repeated flash reads from a small direct-mapped byte cache; only misses go to SPI.
- On a miss it drives the controller's chip-enable/address handshake, stretches the CPU with MRDY until the byte returns, then fills the line.
- Writes to the flash window are acknowledged and discarded.

Parameters:
- IDX_W, 4, index bits; cache holds 2**IDX_W one-byte lines; tag width = 16-IDX_W.
- TIMEOUT, 1023, max clk cycles in a miss before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- i_RESET_N  in  1  synchronous active-low reset
- i_CS  in  1  flash window select from address decoder
- i_ADDRESS_BUS  in  16  CPU address
- i_RW  in  1  1=read, 0=write
- i_FLUSH  in  1  single-cycle pulse: invalidate all lines
- o_DATA  out  8  read data to CPU
- o_MRDY  out  1  1=CPU may proceed, 0=stretch
- o_FLASH_CE  out  1  request to SPI controller
- o_FLASH_ADDR  out  16  address to SPI controller
- i_FLASH_DATA  in  8  byte from SPI controller
- i_FLASH_READY  in  1  SPI controller ready (1=idle/done, 0=busy)
- o_TIMEOUT  out  1  sticky: a miss timed out

Behaviour:
- All state changes on posedge clk. Reset is synchronous and active-low (i_RESET_N=0 at the edge).
- Reset values:
  - Outputs: o_DATA=8'hFF, o_MRDY=1, o_FLASH_CE=0, o_FLASH_ADDR=0, o_TIMEOUT=0.
  - Internal: all valid bits=0, state=IDLE, flush_pending=0.
- Reset mid-miss aborts immediately: CE drops, no fill occurs.
- Index = addr[IDX_W-1:0]; tag = addr[15:IDX_W]; one valid bit per line.
- States:
  - IDLE:
    - i_CS=1 and i_RW=1: latch address, go to LOOKUP.
    - i_CS=1 and i_RW=0: no cache change, go to DONE.
  - LOOKUP (1 cycle):
    - Hit (valid && tag match): o_DATA<=line data, go to DONE. o_MRDY stays 1; hit latency is 2 cycles from CS to data.
    - Miss: o_MRDY<=0, o_FLASH_CE<=1, o_FLASH_ADDR<=latched addr, clear timer, go to REQ.
  - REQ: hold CE=1 until i_FLASH_READY=0 (controller started), then CE<=0 and go to WAIT.
  - WAIT:
    - On i_FLASH_READY=1: o_DATA<=i_FLASH_DATA, go to FILL.
    - CE must stay 0 in WAIT so the controller does not restart.
  - FILL (1 cycle):
    - Write data and tag, set valid (unless flush_pending), clear flush_pending.
    - o_MRDY<=1, go to DONE.
  - DONE:
    - Hold o_DATA.
    - Go to IDLE when i_CS=0, or when i_ADDRESS_BUS differs from the latched address. This handles back-to-back accesses with CS held high.
- Timeout:
  - The timer runs in REQ and WAIT.
  - When it reaches TIMEOUT: CE<=0, o_DATA<=8'hFF, no fill, o_TIMEOUT<=1, o_MRDY<=1, go to DONE.
- Flush:
  - i_FLUSH clears all valid bits in the cycle after its edge.
  - A flush while in REQ or WAIT sets flush_pending, so the in-flight fill does not set valid; its data is still returned to the CPU.
  - Flush and a FILL in the same cycle: flush wins, and the line ends invalid.
  - Flush and LOOKUP in the same cycle: the lookup uses the pre-flush valid bits.
- i_CS dropping during REQ or WAIT does not cancel the miss. The miss completes and the line fills, then the block returns to IDLE via DONE.
- Writes never set o_MRDY=0 and never assert o_FLASH_CE.
- Aliasing: two addresses with the same index evict each other, with no victim buffer.

Test Plan:
- Reset, then read 16'h1234 with the flash model returning 8'hA5 after 80 cycles -> MRDY low until READY rises; o_DATA=8'hA5; CE high only until READY falls; one SPI request.
- Read 16'h1234 again -> hit: MRDY stays 1; o_DATA=8'hA5 two cycles after CS; CE never asserts.
- Read 16'h1244 (same index, different tag) with the model returning 8'h3C, then read 16'h1234 -> two misses, two SPI requests; data 8'h3C then 8'hA5.
- Flush pulse after filling 16'h0010=8'h77, then read 16'h0010 -> miss; one new SPI request.
- Flush pulsed during WAIT of a miss on 16'h0020 (model 8'h11), then re-read 16'h0020 -> first read returns 8'h11; second read misses again.
- Model never raises READY, TIMEOUT=1023 -> after 1023 cycles: o_DATA=8'hFF, o_MRDY=1, o_TIMEOUT=1, line not valid. Separately: write to 16'h0030 -> MRDY never 0, no CE; a subsequent read of 16'h0030 misses.

Source files
------------

// File: rtl/flash_read_cache.sv
// Direct-mapped one-byte-per-line read cache in front of the SPI flash read controller.
// Hits return in two cycles; misses stretch the CPU via MRDY while the controller fetches the byte.
module flash_read_cache #(
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        i_RESET_N,
  input  logic        i_CS,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic        i_RW,
  input  logic        i_FLUSH,
  output logic [7:0]  o_DATA,
  output logic        o_MRDY,
  output logic        o_FLASH_CE,
  output logic [15:0] o_FLASH_ADDR,
  input  logic [7:0]  i_FLASH_DATA,
  input  logic        i_FLASH_READY,
  output logic        o_TIMEOUT
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 16 - IDX_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [15:0]      r_addr;
  logic [7:0]       r_data [LINES];
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [LINES-1:0] r_valid;
  logic             r_flush_pending;
  logic [CNT_W-1:0] r_timer;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_timeout;

  assign w_idx     = r_addr[IDX_W-1:0];
  assign w_tag     = r_addr[15:IDX_W];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_timeout = (r_timer == TMAX);

  always_ff @(posedge clk) begin
    if (!i_RESET_N) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_valid         <= '0;
      r_flush_pending <= 1'b0;
      r_timer         <= '0;
      o_DATA          <= 8'hFF;
      o_MRDY          <= 1'b1;
      o_FLASH_CE      <= 1'b0;
      o_FLASH_ADDR    <= '0;
      o_TIMEOUT       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_CS) begin
            // Writes latch the address too, so DONE can tell when the access ends.
            r_addr  <= i_ADDRESS_BUS;
            r_state <= i_RW ? S_LOOKUP : S_DONE;
          end
        end

        S_LOOKUP: begin
          if (w_hit) begin
            o_DATA  <= r_data[w_idx];
            r_state <= S_DONE;
          end else begin
            o_MRDY       <= 1'b0;
            o_FLASH_CE   <= 1'b1;
            o_FLASH_ADDR <= r_addr;
            r_timer      <= '0;
            r_state      <= S_REQ;
          end
        end

        S_REQ, S_WAIT: begin
          if (i_FLUSH) r_flush_pending <= 1'b1;
          if (w_timeout) begin
            o_FLASH_CE      <= 1'b0;
            o_DATA          <= 8'hFF;
            o_TIMEOUT       <= 1'b1;
            o_MRDY          <= 1'b1;
            r_flush_pending <= 1'b0;
            r_state         <= S_DONE;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
            if (r_state == S_REQ) begin
              if (!i_FLASH_READY) begin
                o_FLASH_CE <= 1'b0;
                r_state    <= S_WAIT;
              end
            end else if (i_FLASH_READY) begin
              o_DATA  <= i_FLASH_DATA;
              r_state <= S_FILL;
            end
          end
        end

        S_FILL: begin
          r_data[w_idx] <= o_DATA;
          r_tag[w_idx]  <= w_tag;
          if (!r_flush_pending) r_valid[w_idx] <= 1'b1;
          r_flush_pending <= 1'b0;
          o_MRDY          <= 1'b1;
          r_state         <= S_DONE;
        end

        S_DONE: begin
          if (!i_CS || (i_ADDRESS_BUS != r_addr)) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      // Placed last so a concurrent flush overrides the valid bit set by FILL.
      if (i_FLUSH) r_valid <= '0;
    end
  end

endmodule

// File: tb/tb_flash_read_cache.sv
// Scoreboard bench for flash_read_cache: directed accesses push expectations,
// a monitor compares data, MRDY stretch, CE activity and timeout at each access end.
module tb_flash_read_cache;

  logic        clk = 1'b0;
  logic        i_RESET_N;
  logic        i_CS;
  logic [15:0] i_ADDRESS_BUS;
  logic        i_RW;
  logic        i_FLUSH;
  logic [7:0]  o_DATA;
  logic        o_MRDY;
  logic        o_FLASH_CE;
  logic [15:0] o_FLASH_ADDR;
  logic [7:0]  i_FLASH_DATA;
  logic        i_FLASH_READY;
  logic        o_TIMEOUT;

  always #5 clk = ~clk;

  flash_read_cache #(.IDX_W(4), .TIMEOUT(1023)) dut (
    .clk          (clk),
    .i_RESET_N    (i_RESET_N),
    .i_CS         (i_CS),
    .i_ADDRESS_BUS(i_ADDRESS_BUS),
    .i_RW         (i_RW),
    .i_FLUSH      (i_FLUSH),
    .o_DATA       (o_DATA),
    .o_MRDY       (o_MRDY),
    .o_FLASH_CE   (o_FLASH_CE),
    .o_FLASH_ADDR (o_FLASH_ADDR),
    .i_FLASH_DATA (i_FLASH_DATA),
    .i_FLASH_READY(i_FLASH_READY),
    .o_TIMEOUT    (o_TIMEOUT)
  );

  typedef struct {
    logic [7:0]  data;
    int          lo;
    int          hi;
    int          nce;
    logic [15:0] addr;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          pass = 0;
  int          total = 0;
  int          lat = 10;
  logic [7:0]  fdata = 8'h00;
  logic        hang = 1'b0;
  logic        txn_done = 1'b0;
  int          mon_nlow = 0;
  int          mon_nce = 0;
  logic [15:0] mon_ce_addr = '0;
  exp_t        mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  // SPI controller model: drops READY right after CE, returns fdata after lat cycles.
  initial begin
    i_FLASH_READY = 1'b1;
    i_FLASH_DATA  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (o_FLASH_CE === 1'b1 && i_FLASH_READY) begin
        i_FLASH_READY = 1'b0;
        repeat (lat) @(posedge clk);
        while (hang) @(posedge clk);
        #1;
        i_FLASH_DATA  = fdata;
        i_FLASH_READY = 1'b1;
      end
    end
  end

  // Monitor: accumulates MRDY-low and CE-high cycles, compares when an access completes.
  initial begin
    forever begin
      @(posedge clk); #3;
      if (i_RESET_N === 1'b1) begin
        if (o_MRDY !== 1'b1) mon_nlow++;
        if (o_FLASH_CE === 1'b1) begin
          mon_nce++;
          mon_ce_addr = o_FLASH_ADDR;
        end
        if (txn_done) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_underflow: got access with empty queue, expected queued entry");
          end else begin
            mon_e = sb.pop_front();
            check("data", 32'(o_DATA), 32'(mon_e.data));
            check_rng("mrdy_low_cycles", mon_nlow, mon_e.lo, mon_e.hi);
            check("ce_cycles", 32'(mon_nce), 32'(mon_e.nce));
            if (mon_e.nce > 0) check("flash_addr", 32'(mon_ce_addr), 32'(mon_e.addr));
            check("timeout_flag", 32'(o_TIMEOUT), 32'(mon_e.to));
          end
          mon_nlow = 0;
          mon_nce  = 0;
        end
      end
    end
  end

  // One CPU access; fl = cycle (from CS) at which FLUSH is pulsed, -1 for none.
  task automatic txn(input logic rw, input logic [15:0] a, input int l, input logic [7:0] d,
                     input int fl, input logic [7:0] edata, input int lo, input int hi,
                     input int nce, input logic eto);
    int   cyc;
    exp_t e;
    e.data = edata; e.lo = lo; e.hi = hi; e.nce = nce; e.addr = a; e.to = eto;
    sb.push_back(e);
    lat = l;
    fdata = d;
    i_CS = 1'b1;
    i_RW = rw;
    i_ADDRESS_BUS = a;
    i_FLUSH = (fl == 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      i_FLUSH = (cyc == fl);
    end while ((cyc < 2 || o_MRDY !== 1'b1) && cyc < 3000);
    if (cyc >= 3000) begin
      total++;
      $display("FAIL access_bound: got MRDY=%b after %0d cycles, expected 1", o_MRDY, cyc);
    end
    i_FLUSH  = 1'b0;
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
    i_CS = 1'b0;
    i_RW = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_RESET_N = 1'b0;
    i_CS = 1'b0;
    i_RW = 1'b1;
    i_FLUSH = 1'b0;
    i_ADDRESS_BUS = '0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(o_DATA), 32'hFF);
    check("rst_mrdy", 32'(o_MRDY), 32'd1);
    check("rst_ce", 32'(o_FLASH_CE), 32'd0);
    check("rst_addr", 32'(o_FLASH_ADDR), 32'd0);
    check("rst_timeout", 32'(o_TIMEOUT), 32'd0);
    i_RESET_N = 1'b1;
    @(negedge clk);

    // Misses stretch MRDY for lat+2 cycles; hits never drop MRDY.
    txn(1'b1, 16'h1234, 80, 8'hA5, -1, 8'hA5, 82, 82, 1, 1'b0);
    txn(1'b1, 16'h0010, 10, 8'h77, -1, 8'h77, 12, 12, 1, 1'b0);
    txn(1'b1, 16'h1234, 10, 8'h00, -1, 8'hA5, 0, 0, 0, 1'b0);
    // Aliasing on index 4.
    txn(1'b1, 16'h1244, 20, 8'h3C, -1, 8'h3C, 22, 22, 1, 1'b0);
    txn(1'b1, 16'h1234, 20, 8'hA5, -1, 8'hA5, 22, 22, 1, 1'b0);
    // Flush in the LOOKUP cycle: lookup still sees the old valid bits.
    txn(1'b1, 16'h0010, 10, 8'h00, 1, 8'h77, 0, 0, 0, 1'b0);
    txn(1'b1, 16'h0010, 10, 8'h77, -1, 8'h77, 12, 12, 1, 1'b0);
    txn(1'b1, 16'h0010, 10, 8'h00, -1, 8'h77, 0, 0, 0, 1'b0);
    i_FLUSH = 1'b1;
    @(negedge clk);
    i_FLUSH = 1'b0;
    @(negedge clk);
    txn(1'b1, 16'h0010, 10, 8'h77, -1, 8'h77, 12, 12, 1, 1'b0);
    // Flush during WAIT: data returned but line left invalid.
    txn(1'b1, 16'h0020, 30, 8'h11, 10, 8'h11, 32, 32, 1, 1'b0);
    txn(1'b1, 16'h0020, 30, 8'h11, -1, 8'h11, 32, 32, 1, 1'b0);
    // Controller never finishes: abort after the timer expires.
    hang = 1'b1;
    txn(1'b1, 16'h0040, 0, 8'h00, -1, 8'hFF, 1023, 1025, 1, 1'b1);
    hang = 1'b0;
    repeat (5) @(negedge clk);
    txn(1'b0, 16'h0030, 5, 8'h00, -1, 8'hFF, 0, 0, 0, 1'b1);
    txn(1'b1, 16'h0030, 5, 8'h5A, -1, 8'h5A, 7, 7, 1, 1'b1);
    txn(1'b1, 16'h0040, 5, 8'h44, -1, 8'h44, 7, 7, 1, 1'b1);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
